// File: rtl/fifo_frame_pkg.sv
// rtl/fifo_frame_pkg.sv - constants and state encodings shared by the ADS-B FIFO fill and unpack logic
package fifo_frame_pkg;

    localparam logic [19:0] HDR_SYNC        = 20'hAD50B;
    localparam int          SHORT_WORDS     = 4;
    localparam int          LONG_WORDS      = 7;
    localparam int          HALF_WORD_PAIRS = 8;
    localparam int          FRAME_BITS      = 112;

    typedef enum logic [2:0] {
        HUNT_RD   = 3'b000,
        HUNT_WAIT = 3'b001,
        DATA_RD   = 3'b010,
        DATA_WAIT = 3'b011,
        PRESENT   = 3'b100
    } unpack_state_e;

    // The final word of a short frame only carries its upper half-word of pairs.
    function automatic logic [15:0] slot_mask(input logic half_only);
        return half_only ? {{HALF_WORD_PAIRS{1'b1}}, {HALF_WORD_PAIRS{1'b0}}} : 16'hFFFF;
    endfunction

endpackage

// File: rtl/fifo_frame_unpacker_if.sv
// rtl/fifo_frame_unpacker_if.sv - FIFO read side and frame presentation side of the unpacker
interface fifo_frame_unpacker_if #(
    parameter int width = 10
) ();

    logic [31:0]      fifo_data;
    logic             fifo_empty;
    logic             fifo_rd;
    logic [111:0]     frame_data;
    logic [111:0]     frame_conf;
    logic             frame_long;
    logic [width-1:0] frame_thresh;
    logic             frame_valid;
    logic             frame_ack;

    modport master (
        input  fifo_data, fifo_empty, frame_ack,
        output fifo_rd, frame_data, frame_conf, frame_long, frame_thresh, frame_valid
    );

    modport slave (
        output fifo_data, fifo_empty, frame_ack,
        input  fifo_rd, frame_data, frame_conf, frame_long, frame_thresh, frame_valid
    );

endinterface

// File: rtl/fifo_word_deinterleave.sv
// rtl/fifo_word_deinterleave.sv - splits a word of {data,conf} bit pairs into 16 data and 16 conf bits
module fifo_word_deinterleave (
    input  logic [31:0] word_i,
    output logic [15:0] data_o,
    output logic [15:0] conf_o
);

    always_comb begin
        data_o = '0;
        conf_o = '0;
        for (int j = 0; j < 16; j++) begin
            data_o[15-j] = word_i[31-2*j];
            conf_o[15-j] = word_i[30-2*j];
        end
    end

endmodule

// File: rtl/fifo_frame_unpacker.sv
// rtl/fifo_frame_unpacker.sv - hunts the header word, assembles a 56/112-bit frame and presents it
module fifo_frame_unpacker
    import fifo_frame_pkg::*;
#(
    parameter int width = 10
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  ena,
    fifo_frame_unpacker_if.master bus,
    output logic                  hdr_err,
    output logic [7:0]            drop_count,
    output logic [2:0]            state_out
);

    unpack_state_e    state_q, state_d;
    logic [2:0]       word_cnt_q, word_cnt_d;
    logic [111:0]     data_q, data_d;
    logic [111:0]     conf_q, conf_d;
    logic             long_q, long_d;
    logic [width-1:0] thresh_q, thresh_d;
    logic             hdr_err_q, hdr_err_d;
    logic [7:0]       drop_q, drop_d;

    logic             rd_ok;
    logic             hdr_hit;
    logic             long_now;
    logic             last_word;
    logic [11:0]      thresh_mask;
    logic [15:0]      dw_data, dw_conf, mask;
    logic [6:0]       slot_shift;

    fifo_word_deinterleave u_deint (
        .word_i (bus.fifo_data),
        .data_o (dw_data),
        .conf_o (dw_conf)
    );

    // Reset gates the strobe so no read escapes while the FSM is held in HUNT_RD.
    assign rd_ok = reset && ena && !bus.fifo_empty &&
                   ((state_q == HUNT_RD) || (state_q == DATA_RD));

    assign thresh_mask = 12'((1 << width) - 1);
    assign hdr_hit     = (bus.fifo_data[31:12] == HDR_SYNC) &&
                         ((bus.fifo_data[11:0] & ~thresh_mask) == 12'd0);

    // Word 0 decides the length in the same cycle it is captured.
    assign long_now   = (word_cnt_q == 3'd0) ? bus.fifo_data[31] : long_q;
    assign last_word  = (word_cnt_q == (long_now ? 3'(LONG_WORDS - 1) : 3'(SHORT_WORDS - 1)));
    assign mask       = slot_mask(!long_now && last_word);
    assign slot_shift = {word_cnt_q, 4'b0000};

    always_comb begin
        state_d    = state_q;
        word_cnt_d = word_cnt_q;
        data_d     = data_q;
        conf_d     = conf_q;
        long_d     = long_q;
        thresh_d   = thresh_q;
        hdr_err_d  = 1'b0;
        drop_d     = drop_q;
        case (state_q)
            HUNT_RD: begin
                if (rd_ok) state_d = HUNT_WAIT;
            end
            HUNT_WAIT: begin
                if (hdr_hit) begin
                    thresh_d   = bus.fifo_data[width-1:0];
                    word_cnt_d = 3'd0;
                    data_d     = '0;
                    conf_d     = '0;
                    long_d     = 1'b0;
                    state_d    = DATA_RD;
                end else begin
                    hdr_err_d = 1'b1;
                    if (drop_q != 8'hFF) drop_d = drop_q + 8'd1;
                    state_d   = HUNT_RD;
                end
            end
            DATA_RD: begin
                if (rd_ok) state_d = DATA_WAIT;
            end
            DATA_WAIT: begin
                data_d = data_q | ({dw_data & mask, 96'd0} >> slot_shift);
                conf_d = conf_q | ({dw_conf & mask, 96'd0} >> slot_shift);
                if (word_cnt_q == 3'd0) long_d = long_now;
                if (last_word) begin
                    state_d = PRESENT;
                end else begin
                    word_cnt_d = word_cnt_q + 3'd1;
                    state_d    = DATA_RD;
                end
            end
            PRESENT: begin
                if (bus.frame_ack) state_d = HUNT_RD;
            end
            default: state_d = HUNT_RD;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= HUNT_RD;
            word_cnt_q <= '0;
            data_q     <= '0;
            conf_q     <= '0;
            long_q     <= 1'b0;
            thresh_q   <= '0;
            hdr_err_q  <= 1'b0;
            drop_q     <= '0;
        end else begin
            state_q    <= state_d;
            word_cnt_q <= word_cnt_d;
            data_q     <= data_d;
            conf_q     <= conf_d;
            long_q     <= long_d;
            thresh_q   <= thresh_d;
            hdr_err_q  <= hdr_err_d;
            drop_q     <= drop_d;
        end
    end

    assign bus.fifo_rd      = rd_ok;
    assign bus.frame_data   = data_q;
    assign bus.frame_conf   = conf_q;
    assign bus.frame_long   = long_q;
    assign bus.frame_thresh = thresh_q;
    assign bus.frame_valid  = (state_q == PRESENT);
    assign hdr_err          = hdr_err_q;
    assign drop_count       = drop_q;
    assign state_out        = state_q;

endmodule

// File: doc/fifo_frame_unpacker.md
Name: fifo_frame_unpacker

Overview:
- Reader end of the ADS-B receive FIFO. Pops 32-bit words written by the receiver's FIFO fill logic.
- Finds the header word, then de-interleaves {data,conf} bit pairs into a parallel 56- or 112-bit frame with a matching confidence vector.
- Presents the frame with a valid/ack handshake to downstream logic (CRC check, host register bank).

Parameters:
- width, 10: RX threshold field width carried in the header word, bits [width-1:0].

Ports:
- clock, in, 1: main system clock. Single clock domain.
- reset, in, 1: asynchronous, active-low reset.
- ena, in, 1: enable. When low, no new FIFO reads are issued.
- fifo_data, in, 32: FIFO read data, valid the cycle after fifo_rd.
- fifo_empty, in, 1: FIFO empty flag.
- fifo_rd, out, 1: FIFO read strobe.
- frame_data, out, 112: frame bits, MSB first. First received bit is at [111].
- frame_conf, out, 112: confidence bit per frame bit, same alignment as frame_data.
- frame_long, out, 1: 1 = 112-bit frame, 0 = 56-bit frame.
- frame_thresh, out, width: threshold value taken from the header.
- frame_valid, out, 1: frame available.
- frame_ack, in, 1: downstream has accepted the frame.
- hdr_err, out, 1: one-cycle pulse when a non-header word is discarded while hunting.
- drop_count, out, 8: saturating count of discarded words.
- state_out, out, 3: state machine state, for debug.

Behaviour:
- Reset (async assert, sync release): every output is 0, state = HUNT_RD, and internal word counter and shift registers are cleared.
- FIFO read protocol:
  - fifo_rd is asserted for exactly one cycle, and only when ena=1, !fifo_empty and the state is a *_RD state.
  - fifo_data is captured in the following *_WAIT state.
  - At most one read is issued per 2 cycles.
  - A read already issued completes its capture even if ena drops.
- Header match: fifo_data[31:12] == 20'hAD50B and fifo_data[11:width] == 0.
- Word layout: for word k (k = 0 is the first word after the header) and j = 0..15:
  - fifo_data[31-2j] -> frame_data[111-16k-j]
  - fifo_data[30-2j] -> frame_conf[111-16k-j]
- Frame length:
  - Decided from bit [31] of data word 0, which is DF MSB.
  - 1 = long: 7 data words.
  - 0 = short: 4 data words. Only the upper 16 bits (8 pairs) of word 3 are used; the low 16 bits are ignored.
  - For short frames, frame_data[55:0] and frame_conf[55:0] are 0.
- States:
  - HUNT_RD (000): issue read, then go to HUNT_WAIT.
  - HUNT_WAIT (001): capture the word.
    - Header match: latch thresh, clear the word counter and assembly registers, go to DATA_RD.
    - No match: pulse hdr_err, increment drop_count (saturates at 0xFF), go to HUNT_RD.
  - DATA_RD (010): issue read, then go to DATA_WAIT.
  - DATA_WAIT (011): capture and de-interleave the word into slot k.
    - On k = 0, latch frame_long.
    - After the last word (k = 3 short, k = 6 long), go to PRESENT. Otherwise k++ and return to DATA_RD.
  - PRESENT (100): frame_valid = 1, outputs are stable, no reads.
    - On frame_ack=1, frame_valid drops next cycle and the state goes to HUNT_RD.
  - Encodings 101–111 go to HUNT_RD.
- Mid-frame behaviour:
  - No resync inside a frame: a header-valued word in DATA_WAIT is treated as data.
  - The writer's length-error truncation is recovered at the next hunt.
- frame_ack outside PRESENT is ignored.
- fifo_empty stalls any *_RD state indefinitely without side effects.
- Latency: with a non-empty FIFO and ena=1, frame_valid rises 2×(N+1) cycles after the header's fifo_rd, where N = 4 or 7.
- Reset asserted mid-frame: outputs clear immediately and the partial frame is lost. No FIFO flush is performed; hunting resumes after reset.

Decomposition:
- Shared package fifo_frame_pkg:
  - HDR_SYNC = 20'hAD50B
  - SHORT_WORDS = 4
  - LONG_WORDS = 7
  - HALF_WORD_PAIRS = 8
  - 3-bit state encodings
  - These constants are shared with the receiver's FIFO fill logic.
- One sub-module: fifo_word_deinterleave. Combinational: 32-bit word in, 16-bit data and 16-bit conf out.

Test Plan:
- Short frame: push 0xAD50B155, 0x7FFFFFFF, 0xFFFFFFFF, 0xFFFFFFFF, 0xAAAA0000. Expect:
  - frame_long=0, frame_thresh=0x155
  - frame_data[111:56] = 0x7FFF_FFFF_FFFF_FF, frame_conf[111:56] = 0xFFFF_FFFF_FFFF_00
  - bits [55:0] = 0
  - frame_valid after 10 cycles.
- Long frame: push header 0xAD50B3FF, then 0x80000000 and six words of 0x55555555. Expect:
  - frame_long=1, frame_thresh=0x3FF
  - frame_data = {1'b1, 111'b0}
  - frame_conf[111] = 0, frame_conf[110:96] = 0; the six 0x55555555 words give frame_conf[95:0] all ones
  - valid after 16 cycles.
- Junk before header: push 0x12345678 and 0xAD50C000, then a valid short frame. Expect:
  - two hdr_err pulses, drop_count=2
  - the short frame is decoded correctly.
- Backpressure: hold frame_ack=0 for 20 cycles with the FIFO non-empty. Expect frame_valid held, fifo_rd=0, outputs stable. Assert ack: valid drops next cycle and hunting resumes.
- Stall and enable: assert fifo_empty or ena=0 for 5 cycles between data words. Expect no fifo_rd, no state advance, and an identical decoded frame.
- Reset mid-frame: assert reset during word 2. Expect all outputs 0 asynchronously. After release, hunting resumes and the next header decodes normally.
